// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the two-port line-memory arbiter
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_P0 = 1'b0,
        OWNER_P1 = 1'b1
    } owner_e;

    function automatic owner_e other_port(input owner_e o);
        return (o == OWNER_P0) ? OWNER_P1 : OWNER_P0;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational grant selection; MEM_ARB_RR_EN selects round-robin,
// otherwise port 1 (D-cache) wins every contention.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   req0_i,
    input  logic   req1_i,
    input  owner_e prio_i,
    output logic   grant_o,
    output owner_e owner_o
);

    assign grant_o = req0_i | req1_i;

`ifdef MEM_ARB_RR_EN
    // prio_i names the port that wins a tie; a lone requester always wins.
    always_comb begin
        owner_o = prio_i;
        if (req0_i && !req1_i) begin
            owner_o = OWNER_P0;
        end else if (req1_i && !req0_i) begin
            owner_o = OWNER_P1;
        end
    end
`else
    logic unused_prio;
    assign unused_prio = prio_i;
    assign owner_o     = req1_i ? OWNER_P1 : OWNER_P0;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates I-side and D-cache line requests onto one Data_Memory port;
// define MEM_ARB_RR_EN for round-robin arbitration instead of fixed D-cache priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_enable_i,
    input  logic              req0_write_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ack_o,
    output logic [DATA_W-1:0] req0_data_o,

    input  logic              req1_enable_i,
    input  logic              req1_write_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ack_o,
    output logic [DATA_W-1:0] req1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            prio_q,  prio_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;

    logic              pick_grant;
    owner_e            pick_owner;
    logic              busy;

    mem_arb_pick u_pick (
        .req0_i  (req0_enable_i),
        .req1_i  (req1_enable_i),
        .prio_i  (prio_q),
        .grant_o (pick_grant),
        .owner_o (pick_owner)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            owner_q <= OWNER_P0;
            prio_q  <= OWNER_P1;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Requests are only sampled in IDLE, so RELEASE enforces the two-cycle gap after an ack.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        write_d = write_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (pick_grant) begin
                    owner_d = pick_owner;
                    prio_d  = other_port(pick_owner);
                    state_d = BUSY;
                    if (pick_owner == OWNER_P1) begin
                        write_d = req1_write_i;
                        addr_d  = req1_addr_i;
                        data_d  = req1_data_i;
                    end else begin
                        write_d = req0_write_i;
                        addr_d  = req0_addr_i;
                        data_d  = req0_data_i;
                    end
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == BUSY);

    // Everything downstream is gated by BUSY so a reset or stray mem_ack_i cannot leak out.
    always_comb begin
        mem_enable_o = busy;
        mem_write_o  = busy & write_q;
        mem_addr_o   = busy ? addr_q : '0;
        mem_data_o   = busy ? data_q : '0;
        req0_ack_o   = busy & mem_ack_i & (owner_q == OWNER_P0);
        req1_ack_o   = busy & mem_ack_i & (owner_q == OWNER_P1);
        req0_data_o  = (busy && owner_q == OWNER_P0) ? mem_data_i : '0;
        req1_data_o  = (busy && owner_q == OWNER_P1) ? mem_data_i : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural line-memory model
module tb_mem_arbiter;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wd;
        logic [255:0] rd;
    } exp_t;

    localparam logic [255:0] LINE1 =
        256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_7777_6666_5555_4444_3333_2222_1111_0000;
    localparam logic [255:0] ECFA =
        256'hECFA_0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         req0_enable_i, req0_write_i, req1_enable_i, req1_write_i;
    logic [31:0]  req0_addr_i, req1_addr_i;
    logic [255:0] req0_data_i, req1_data_i;
    logic         req0_ack_o, req1_ack_o;
    logic [255:0] req0_data_o, req1_data_o;
    logic         mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_ack_i;
    logic [255:0] mem_data_i;

    logic [255:0] mem_model [0:255];
    logic [255:0] ref_mem   [0:255];
    exp_t         q0[$], q1[$];
    int           ack_log[$];
    int           total = 0, bad = 0;
    int           lat_fixed = -1;
    bit           spur_en = 0;

    int           cyc = 0, m_ready = 0, m_owner = 0, m_last = 0;
    bit           m_busy = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_enable_i(req0_enable_i), .req0_write_i(req0_write_i),
        .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
        .req0_ack_o(req0_ack_o), .req0_data_o(req0_data_o),
        .req1_enable_i(req1_enable_i), .req1_write_i(req1_write_i),
        .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
        .req1_ack_o(req1_ack_o), .req1_data_o(req1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Line memory: services a request after lat_fixed (or random) extra cycles.
    int mm_cnt = 0;
    bit mm_active = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_i) begin
                mm_active = 0;
                mem_ack_i = 1'b0;
            end else if (mem_enable_o) begin
                if (!mm_active) begin
                    mm_active = 1;
                    mm_cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 6));
                end
                if (mm_cnt == 0) begin
                    mem_ack_i = 1'b1;
                    mm_active = 0;
                    if (mem_write_o) begin
                        mem_model[mem_addr_o[12:5]] = mem_data_o;
                        mem_data_i = rnd256();
                    end else begin
                        mem_data_i = mem_model[mem_addr_o[12:5]];
                    end
                end else begin
                    mm_cnt--;
                    mem_ack_i  = 1'b0;
                    mem_data_i = rnd256();
                end
            end else begin
                mm_active  = 0;
                mem_ack_i  = spur_en && ($urandom_range(0, 3) == 0);
                mem_data_i = rnd256();
            end
        end
    end

    // Reference model and scoreboard: predicts the grant from the sampled requests and the
    // arbitration rule, then compares every output against the predicted transaction.
    always @(negedge clk) begin
        exp_t f;
        bit   have;
        cyc++;
        if (!rst_i) begin
            chk("rst_mem_en", mem_enable_o, 0);
            chk("rst_mem_wr", mem_write_o, 0);
            chk("rst_mem_addr", mem_addr_o, 0);
            chk("rst_mem_wdata", mem_data_o, 0);
            chk("rst_ack0", req0_ack_o, 0);
            chk("rst_ack1", req1_ack_o, 0);
            chk("rst_rd0", req0_data_o, 0);
            chk("rst_rd1", req1_data_o, 0);
            m_busy = 0; m_last = 0; m_ready = 0;
            q0.delete(); q1.delete();
        end else begin
            chk("mem_en", mem_enable_o, m_busy);
            if (m_busy) begin
                have = (m_owner == 0) ? (q0.size() > 0) : (q1.size() > 0);
                chk("sb_pending", have, 1);
                if (have) begin
                    f = (m_owner == 0) ? q0[0] : q1[0];
                    chk("mem_wr", mem_write_o, f.wr);
                    chk("mem_addr", mem_addr_o, f.addr);
                    chk("mem_wdata", mem_data_o, f.wd);
                    if (mem_ack_i) begin
                        if (m_owner == 0) f = q0.pop_front(); else f = q1.pop_front();
                        if (f.wr) chk("mem_line", mem_model[f.addr[12:5]], f.wd);
                        else      chk("rdata", (m_owner == 0) ? req0_data_o : req1_data_o, f.rd);
                        ack_log.push_back(m_owner);
                    end
                end
            end
            chk("ack0", req0_ack_o, m_busy && mem_ack_i && m_owner == 0);
            chk("ack1", req1_ack_o, m_busy && mem_ack_i && m_owner == 1);
            chk("rd0", req0_data_o, (m_busy && m_owner == 0) ? mem_data_i : 256'd0);
            chk("rd1", req1_data_o, (m_busy && m_owner == 1) ? mem_data_i : 256'd0);
            if (m_busy) begin
                if (mem_ack_i) begin
                    m_busy  = 0;
                    m_ready = cyc + 2;
                end
            end else if (cyc >= m_ready && (req0_enable_i || req1_enable_i)) begin
                if (req0_enable_i && req1_enable_i) begin
`ifdef MEM_ARB_RR_EN
                    m_owner = (m_last == 0) ? 1 : 0;
`else
                    m_owner = 1;
`endif
                end else begin
                    m_owner = req1_enable_i ? 1 : 0;
                end
                m_busy = 1;
                m_last = m_owner;
            end
        end
    end

    // One request/response handshake; caller enters just after a rising edge.
    task automatic do_txn(input int p, input bit wr, input logic [31:0] addr,
                          input logic [255:0] wd, input bit drop);
        exp_t e;
        bit   done, granted;
        e.wr = wr; e.addr = addr; e.wd = wd; e.rd = ref_mem[addr[12:5]];
        if (wr) ref_mem[addr[12:5]] = wd;
        if (p == 0) begin
            q0.push_back(e);
            req0_write_i = wr; req0_addr_i = addr; req0_data_i = wd; req0_enable_i = 1'b1;
        end else begin
            q1.push_back(e);
            req1_write_i = wr; req1_addr_i = addr; req1_data_i = wd; req1_enable_i = 1'b1;
        end
        done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            done    = (p == 0) ? req0_ack_o : req1_ack_o;
            granted = mem_enable_o && (mem_addr_o == addr);
            @(posedge clk);
            #1;
            if (done || (drop && granted)) begin
                if (p == 0) req0_enable_i = 1'b0; else req1_enable_i = 1'b0;
            end
        end
        chk($sformatf("txn_done_p%0d", p), done, 1);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int   exp_order [3];
        exp_t e;
        bit   seen;
        for (int i = 0; i < 256; i++) begin
            mem_model[i] = {8{32'(i) ^ 32'h5A5A_0000}};
        end
        mem_model[1] = LINE1;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem_model[i];

        rst_i = 1'b0;
        req0_enable_i = 0; req0_write_i = 0; req0_addr_i = '0; req0_data_i = '0;
        req1_enable_i = 0; req1_write_i = 0; req1_addr_i = '0; req1_data_i = '0;
        mem_ack_i = 0; mem_data_i = '0;
        tick(3);
        rst_i = 1'b1;

        // port 1 read of line 0x20, slow memory
        lat_fixed = 10;
        do_txn(1, 0, 32'h0000_0020, rnd256(), 0);

        // port 0 write of line 0x400
        lat_fixed = 2;
        do_txn(0, 1, 32'h0000_0400, ECFA, 0);
        chk("line32", mem_model[32], ECFA);

        // simultaneous requests, port 1 asking twice back-to-back
        lat_fixed = -1;
        ack_log.delete();
        fork
            begin
                do_txn(1, 0, 32'h0000_0060, rnd256(), 0);
                do_txn(1, 1, 32'h0000_0080, rnd256(), 0);
            end
            do_txn(0, 0, 32'h0000_00A0, rnd256(), 0);
        join
`ifdef MEM_ARB_RR_EN
        exp_order = '{1, 0, 1};
`else
        exp_order = '{1, 1, 0};
`endif
        chk("order_len", ack_log.size(), 3);
        for (int i = 0; i < 3 && i < ack_log.size(); i++) begin
            chk($sformatf("order_%0d", i), ack_log[i], exp_order[i]);
        end

        // port 0 drops enable while its transaction is outstanding
        lat_fixed = 5;
        do_txn(0, 0, 32'h0000_00C0, rnd256(), 1);

        // stray mem_ack_i while idle
        spur_en = 1;
        tick(20);
        spur_en = 0;

        // reset in the middle of a transaction
        lat_fixed = 20;
        e.wr = 0; e.addr = 32'h0000_00E0; e.wd = rnd256(); e.rd = ref_mem[7];
        q0.push_back(e);
        req0_write_i = 0; req0_addr_i = e.addr; req0_data_i = e.wd; req0_enable_i = 1;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = mem_enable_o;
        end
        chk("rst_busy_reached", seen, 1);
        tick(2);
        #2;
        rst_i = 1'b0;
        #1;
        chk("async_rst_en", mem_enable_o, 0);
        chk("async_rst_ack0", req0_ack_o, 0);
        chk("async_rst_addr", mem_addr_o, 0);
        chk("async_rst_wdata", mem_data_o, 0);
        req0_enable_i = 0;
        tick(2);
        rst_i = 1'b1;
        lat_fixed = 3;
        do_txn(0, 0, 32'h0000_00E0, rnd256(), 0);

        // random mixed traffic on disjoint address regions
        lat_fixed = -1;
        spur_en = 1;
        fork
            for (int k = 0; k < 30; k++) begin
                tick($urandom_range(0, 3));
                do_txn(0, 1'($urandom_range(0, 1)), 32'(64 + $urandom_range(0, 63)) << 5,
                       rnd256(), $urandom_range(0, 3) == 0);
            end
            for (int k = 0; k < 30; k++) begin
                tick($urandom_range(0, 3));
                do_txn(1, 1'($urandom_range(0, 1)), 32'(128 + $urandom_range(0, 63)) << 5,
                       rnd256(), $urandom_range(0, 3) == 0);
            end
        join
        spur_en = 0;
        tick(5);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 256, cache-line width (32-byte line).
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports req0_enable_i / req1_enable_i  input  1  request from port 0 (I-side) / port 1 (D-cache).
REQ-006 SHALL have ports req0_write_i / req1_write_i  input  1  1 = line write, 0 = line read.
REQ-007 SHALL have ports req0_addr_i / req1_addr_i  input  ADDR_W  line address.
REQ-008 SHALL have ports req0_data_i / req1_data_i  input  DATA_W  write data.
REQ-009 SHALL have ports req0_ack_o / req1_ack_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports req0_data_o / req1_data_o  output  DATA_W  read data.
REQ-011 SHALL have ports mem_enable_o, mem_write_o (output 1), mem_addr_o (output ADDR_W), mem_data_o (output DATA_W): downstream Data_Memory request.
REQ-012 SHALL have ports mem_ack_i (input 1), mem_data_i (input DATA_W): downstream completion.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RELEASE.
REQ-014 In IDLE with any reqN_enable_i high, SHALL register grant owner, write, addr and data, then enter BUSY on the next edge.
REQ-015 In BUSY, mem_enable_o SHALL be 1 and mem_write_o/mem_addr_o/mem_data_o SHALL equal the latched values, stable until mem_ack_i.
REQ-016 In BUSY with mem_ack_i = 1, SHALL drive owner's reqN_ack_o = 1 combinationally in that same cycle and enter RELEASE.
REQ-017 reqN_data_o SHALL equal mem_data_i while N is owner in BUSY, else all-zero.
REQ-018 RELEASE SHALL last exactly one cycle with mem_enable_o = 0, then go to IDLE; no grant is made in RELEASE.
REQ-019 Request-to-mem_enable_o latency SHALL be one cycle; ack-to-next-grant minimum two cycles.
REQ-020 Simultaneous requests SHALL be resolved per REQ-027/REQ-028; the loser is served by the next grant if still requesting.
REQ-021 A requester deasserting enable in BUSY SHALL NOT abort the transaction; it completes and the ack is still pulsed.
REQ-022 mem_ack_i in IDLE or RELEASE SHALL be ignored: no reqN_ack_o, no state change.
REQ-023 Non-owner ack SHALL remain 0 at all times.

Reset
REQ-024 rst_i low SHALL immediately force IDLE, all outputs 0, latched fields 0, priority pointer to port 1.
REQ-025 Reset asserted in BUSY SHALL abandon the transaction with no ack pulse.
REQ-026 First grant after reset release SHALL occur no earlier than the first rising edge with rst_i high.

Configuration
REQ-027 With macro MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on contention, the port not granted last wins; the pointer updates on each grant.
REQ-028 Without MEM_ARB_RR_EN, SHALL use fixed priority, port 1 (D-cache) always winning contention.

Structure
REQ-029 Shared package mem_arb_pkg SHALL hold the state enum, owner encoding and ADDR_W/DATA_W default constants.
REQ-030 Sub-module mem_arb_pick SHALL implement the combinational grant selection including the MEM_ARB_RR_EN variant; all registers stay in mem_arbiter.

Verification
REQ-031 Port 1 reads addr 0x00000020 alone; memory model acks after 10 cycles -> req1_data_o = 256'h8888_9999_..._1111_0000 with req1_ack_o high one cycle; req0_ack_o stays 0.
REQ-032 Port 0 writes 256'hECFA... to addr 0x00000400 -> memory[32] updated, mem_write_o = 1 throughout BUSY, single ack to port 0.
REQ-033 Both ports request in the same cycle, twice back-to-back -> fixed build: port 1 served twice before port 0; MEM_ARB_RR_EN build: order 1, 0, 1.
REQ-034 Port 0 drops enable mid-BUSY -> mem_enable_o held until mem_ack_i; req0_ack_o pulses once; RELEASE observed.
REQ-035 rst_i pulsed low during BUSY -> outputs 0 within the same cycle, no ack; a fresh request after release is served normally.
REQ-036 Spurious mem_ack_i injected in IDLE -> no ack output, FSM stays IDLE.
